// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// ecc_pkg - shared types and helpers for the ECC operation sequencer (rev 1.0)
// ============================================================================
package ecc_pkg;

    typedef enum logic [1:0] {
        OP_ENC  = 2'd0,
        OP_DEC  = 2'd1,
        OP_FULL = 2'd2
    } ctrl_op_e;

    typedef enum logic [1:0] {
        LEN_8      = 2'd0,
        LEN_16     = 2'd1,
        LEN_32     = 2'd2,
        LEN_32_ALT = 2'd3
    } len_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENC_GO   = 3'd1,
        S_ENC_WAIT = 3'd2,
        S_NOISE    = 3'd3,
        S_DEC_GO   = 3'd4,
        S_DEC_WAIT = 3'd5,
        S_DONE     = 3'd6
    } seq_state_e;

    function automatic logic [31:0] len_mask(input len_e len);
        case (len)
            LEN_8:   len_mask = 32'h0000_00FF;
            LEN_16:  len_mask = 32'h0000_FFFF;
            default: len_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_engine_handshake.sv
`default_nettype none
// ============================================================================
// ecc_engine_handshake - start pulse, operand hold, timeout and result capture
// for one engine (rev 1.0)
// ============================================================================
module ecc_engine_handshake #(
    parameter int DATA_WIDTH     = 32,
    parameter int RES_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] operand_i,
    input  logic                  go_i,
    input  logic                  wait_i,
    input  logic                  done_i,
    input  logic [RES_WIDTH-1:0]  result_i,
    output logic                  eng_start_o,
    output logic [DATA_WIDTH-1:0] eng_data_o,
    output logic                  ok_o,
    output logic                  timeout_o,
    output logic [RES_WIDTH-1:0]  result_o
);

    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [DATA_WIDTH-1:0] operand_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic [RES_WIDTH-1:0]  result_q;

    // A done in the limit cycle is a success, so the timeout is gated by ~done_i.
    assign ok_o        = wait_i & done_i;
    assign timeout_o   = wait_i & ~done_i & (cnt_q == CNT_LIMIT);
    assign eng_start_o = go_i;
    assign eng_data_o  = operand_q;
    assign result_o    = result_q;

    always_comb begin
        cnt_d = cnt_q;
        if (go_i) begin
            cnt_d = '0;
        end else if (wait_i && !done_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            operand_q <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load_i) begin
                operand_q <= operand_i;
            end
            if (ok_o) begin
                result_q <= result_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ecc_op_sequencer.sv
`default_nettype none
// ============================================================================
// ecc_op_sequencer - runs encode, decode or encode->noise->decode per start
// pulse (rev 1.0)
// ============================================================================
module ecc_op_sequencer
    import ecc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            ctrl_op,
    input  logic [1:0]            ctrl_len,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] noise,
    output logic                  enc_start,
    output logic [DATA_WIDTH-1:0] enc_data,
    input  logic                  enc_done,
    input  logic [DATA_WIDTH-1:0] enc_result,
    output logic                  dec_start,
    output logic [DATA_WIDTH-1:0] dec_data,
    input  logic                  dec_done,
    input  logic [DATA_WIDTH-1:0] dec_result,
    input  logic [1:0]            dec_num_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            num_of_errors,
    output logic                  operation_done,
    output logic                  busy,
    output logic                  timeout_err
);

    seq_state_e            state_q, state_d;
    ctrl_op_e              op_q, op_sel;
    len_e                  len_q;
    logic [DATA_WIDTH-1:0] noise_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [1:0]            nerr_q;
    logic                  done_q;
    logic                  tmo_q;

    logic                  accept;
    logic [DATA_WIDTH-1:0] in_mask, op_mask;
    logic                  enc_ok, enc_tmo, dec_ok, dec_tmo, dec_load;
    logic [DATA_WIDTH-1:0] enc_res, dec_operand;
    logic [DATA_WIDTH+1:0] dec_res;

    assign accept  = (state_q == S_IDLE) && start;
    assign in_mask = DATA_WIDTH'(len_mask(len_e'(ctrl_len)));
    assign op_mask = DATA_WIDTH'(len_mask(len_q));

    always_comb begin
        case (ctrl_op)
            2'd1:    op_sel = OP_DEC;
            2'd2:    op_sel = OP_FULL;
            default: op_sel = OP_ENC;
        endcase
    end

    // The decoder operand is either the raw input or the noisy codeword.
    assign dec_load    = (accept && (op_sel == OP_DEC)) || (state_q == S_NOISE);
    assign dec_operand = (state_q == S_NOISE) ? ((enc_res ^ noise_q) & op_mask)
                                              : (data_in & in_mask);

    ecc_engine_handshake #(
        .DATA_WIDTH     (DATA_WIDTH),
        .RES_WIDTH      (DATA_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_enc_hs (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .operand_i   (data_in & in_mask),
        .go_i        (state_q == S_ENC_GO),
        .wait_i      (state_q == S_ENC_WAIT),
        .done_i      (enc_done),
        .result_i    (enc_result),
        .eng_start_o (enc_start),
        .eng_data_o  (enc_data),
        .ok_o        (enc_ok),
        .timeout_o   (enc_tmo),
        .result_o    (enc_res)
    );

    ecc_engine_handshake #(
        .DATA_WIDTH     (DATA_WIDTH),
        .RES_WIDTH      (DATA_WIDTH + 2),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dec_hs (
        .clk         (clk),
        .rst         (rst),
        .load_i      (dec_load),
        .operand_i   (dec_operand),
        .go_i        (state_q == S_DEC_GO),
        .wait_i      (state_q == S_DEC_WAIT),
        .done_i      (dec_done),
        .result_i    ({dec_num_err, dec_result}),
        .eng_start_o (dec_start),
        .eng_data_o  (dec_data),
        .ok_o        (dec_ok),
        .timeout_o   (dec_tmo),
        .result_o    (dec_res)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = (op_sel == OP_DEC) ? S_DEC_GO : S_ENC_GO;
            S_ENC_GO:   state_d = S_ENC_WAIT;
            S_ENC_WAIT: begin
                if (enc_ok)       state_d = (op_q == OP_FULL) ? S_NOISE : S_DONE;
                else if (enc_tmo) state_d = S_IDLE;
            end
            S_NOISE:    state_d = S_DEC_GO;
            S_DEC_GO:   state_d = S_DEC_WAIT;
            S_DEC_WAIT: begin
                if (dec_ok)       state_d = S_DONE;
                else if (dec_tmo) state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ENC;
            len_q      <= LEN_8;
            noise_q    <= '0;
            data_out_q <= '0;
            nerr_q     <= '0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_DONE);
            if (accept) begin
                op_q    <= op_sel;
                len_q   <= len_e'(ctrl_len);
                noise_q <= noise;
                tmo_q   <= 1'b0;
            end else if (enc_tmo || dec_tmo) begin
                tmo_q <= 1'b1;
            end
            if (state_q == S_DONE) begin
                data_out_q <= (op_q == OP_ENC) ? enc_res : dec_res[DATA_WIDTH-1:0];
                nerr_q     <= (op_q == OP_ENC) ? 2'd0 : dec_res[DATA_WIDTH+1:DATA_WIDTH];
            end
        end
    end

    assign data_out       = data_out_q;
    assign num_of_errors  = nerr_q;
    assign operation_done = done_q;
    assign busy           = (state_q != S_IDLE);
    assign timeout_err    = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_op_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ecc_op_sequencer - directed and randomized checks against a reference
// model of the sequencer (rev 1.0)
// ============================================================================
module tb_ecc_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  ctrl_op = 2'd0;
    logic [1:0]  ctrl_len = 2'd0;
    logic [31:0] data_in = '0;
    logic [31:0] noise = '0;
    logic        enc_start, dec_start;
    logic [31:0] enc_data, dec_data;
    logic        enc_done = 1'b0;
    logic        dec_done = 1'b0;
    logic [31:0] enc_result = '0;
    logic [31:0] dec_result = '0;
    logic [1:0]  dec_num_err = 2'd0;
    logic [31:0] data_out;
    logic [1:0]  num_of_errors;
    logic        operation_done, busy, timeout_err;

    ecc_op_sequencer #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ctrl_op        (ctrl_op),
        .ctrl_len       (ctrl_len),
        .data_in        (data_in),
        .noise          (noise),
        .enc_start      (enc_start),
        .enc_data       (enc_data),
        .enc_done       (enc_done),
        .enc_result     (enc_result),
        .dec_start      (dec_start),
        .dec_data       (dec_data),
        .dec_done       (dec_done),
        .dec_result     (dec_result),
        .dec_num_err    (dec_num_err),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .operation_done (operation_done),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    // Engine models: done follows start after a programmable latency (<=0: never).
    int          enc_lat = 1, dec_lat = 1;
    int          enc_cd = 0, dec_cd = 0;
    int          enc_starts = 0, dec_starts = 0, done_cnt = 0;
    logic [31:0] enc_data_seen = '0, dec_data_seen = '0;

    always @(posedge clk) begin
        enc_done <= 1'b0;
        if (enc_start) begin
            enc_starts    <= enc_starts + 1;
            enc_data_seen <= enc_data;
            enc_cd        <= (enc_lat > 0) ? enc_lat : 0;
            if (enc_lat == 1) enc_done <= 1'b1;
        end else if (enc_cd > 1) begin
            enc_cd <= enc_cd - 1;
            if (enc_cd == 2) enc_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        dec_done <= 1'b0;
        if (dec_start) begin
            dec_starts    <= dec_starts + 1;
            dec_data_seen <= dec_data;
            dec_cd        <= (dec_lat > 0) ? dec_lat : 0;
            if (dec_lat == 1) dec_done <= 1'b1;
        end else if (dec_cd > 1) begin
            dec_cd <= dec_cd - 1;
            if (dec_cd == 2) dec_done <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (operation_done) done_cnt <= done_cnt + 1;
    end

    int          checks = 0, errors = 0;
    logic [31:0] exp_dout = '0;
    logic [1:0]  exp_nerr = 2'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [1:0] len);
        case (len)
            2'd0:    mask_of = (32'd1 << 8) - 32'd1;
            2'd1:    mask_of = (32'd1 << 16) - 32'd1;
            default: mask_of = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Launch one operation and compare everything observable with the model.
    task automatic run_op(input logic [1:0] op, input logic [1:0] len,
                          input logic [31:0] d, input logic [31:0] nz,
                          input logic [31:0] er, input logic [31:0] dr,
                          input logic [1:0] ne, input int le, input int ld,
                          input bit dup);
        int n, es0, ds0, dc0, exp_lat, exp_es, exp_ds;
        logic [31:0] m, exp_dd, exp_res;
        logic [1:0]  exp_ne;
        m       = mask_of(len);
        exp_dd  = (op == 2'd1) ? (d & m) : ((er ^ nz) & m);
        exp_lat = (op == 2'd1) ? 3 + ld : (op == 2'd2) ? 5 + le + ld : 3 + le;
        exp_es  = (op == 2'd1) ? 0 : 1;
        exp_ds  = (op == 2'd1 || op == 2'd2) ? 1 : 0;
        exp_res = (op == 2'd1 || op == 2'd2) ? dr : er;
        exp_ne  = (op == 2'd1 || op == 2'd2) ? ne : 2'd0;
        enc_result = er; dec_result = dr; dec_num_err = ne;
        enc_lat = le; dec_lat = ld;
        es0 = enc_starts; ds0 = dec_starts; dc0 = done_cnt;
        @(negedge clk);
        ctrl_op = op; ctrl_len = len; data_in = d; noise = nz; start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = dup && (n == 2);
            if (n == 1) check("busy_after_start", busy, 1);
            if (n == 1) check("timeout_cleared", timeout_err, 0);
        end while (!operation_done && n < 200);
        start = 1'b0;
        check("latency", n, exp_lat);
        check("data_out", data_out, exp_res);
        check("num_of_errors", num_of_errors, exp_ne);
        if (exp_es == 1) check("enc_data", enc_data_seen, d & m);
        if (exp_ds == 1) check("dec_data", dec_data_seen, exp_dd);
        check("enc_start_count", enc_starts - es0, exp_es);
        check("dec_start_count", dec_starts - ds0, exp_ds);
        @(negedge clk);
        check("done_one_cycle", operation_done, 0);
        check("done_count", done_cnt - dc0, 1);
        check("idle_after_done", busy, 0);
        exp_dout = exp_res;
        exp_nerr = exp_ne;
    endtask

    initial begin
        int n, dc0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_nerr", num_of_errors, 0);
        check("rst_done", operation_done, 0);
        check("rst_busy", busy, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_enc_start", enc_start, 0);
        check("rst_dec_start", dec_start, 0);
        check("rst_enc_data", enc_data, 0);
        check("rst_dec_data", dec_data, 0);
        rst = 1'b1;

        // Directed: encode, full channel, length masking, zero-wait latencies
        run_op(2'd0, 2'd0, 32'h0000_00A5, 32'h0, 32'h0000_3CA5, 32'h0, 2'd0, 3, 1, 1'b0);
        run_op(2'd2, 2'd2, 32'h0000_0055, 32'h0000_0004, 32'h1234_5678, 32'h0000_0055, 2'd1, 1, 1, 1'b0);
        run_op(2'd1, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_00AB, 2'd2, 1, 1, 1'b0);
        run_op(2'd0, 2'd2, 32'hDEAD_BEEF, 32'h0, 32'hCAFE_F00D, 32'h0, 2'd0, 1, 1, 1'b0);
        run_op(2'd3, 2'd3, 32'h0F0F_0F0F, 32'h0, 32'h1111_2222, 32'h0, 2'd1, 2, 1, 1'b0);
        // Start while busy: second start ignored
        run_op(2'd0, 2'd1, 32'h0001_2345, 32'h0, 32'h0000_BEEF, 32'h0, 2'd0, 4, 1, 1'b1);
        // Full channel with noise above the codeword length
        run_op(2'd2, 2'd0, 32'h0000_0012, 32'hFFFF_0180, 32'h0000_0F34, 32'h0000_0034, 2'd1, 2, 3, 1'b0);

        // Timeout: encoder never answers
        enc_lat = 0;
        dc0 = done_cnt;
        @(negedge clk);
        ctrl_op = 2'd0; ctrl_len = 2'd2; data_in = 32'h7777_7777; start = 1'b1;
        n = 0;
        repeat (70) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (n == 65) check("tmo_busy_last_wait", busy, 1);
            if (n == 65) check("tmo_not_yet", timeout_err, 0);
            if (n == 66) check("tmo_set", timeout_err, 1);
            if (n == 66) check("tmo_busy_cleared", busy, 0);
        end
        check("tmo_sticky", timeout_err, 1);
        check("tmo_no_done", done_cnt - dc0, 0);
        check("tmo_data_out_held", data_out, exp_dout);
        check("tmo_nerr_held", num_of_errors, exp_nerr);

        // Next start clears timeout_err (checked inside run_op)
        run_op(2'd1, 2'd0, 32'h1234_56C3, 32'h0, 32'h0, 32'h0000_00C3, 2'd0, 1, 2, 1'b0);

        // Reset during DEC_WAIT; the late dec_done must be ignored
        dec_lat = 6;
        dc0 = done_cnt;
        @(negedge clk);
        ctrl_op = 2'd1; ctrl_len = 2'd2; data_in = 32'hABCD_0123; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_nerr", num_of_errors, 0);
        check("midrst_dec_start", dec_start, 0);
        check("midrst_dec_data", dec_data, 0);
        check("midrst_done", operation_done, 0);
        rst = 1'b1;
        exp_dout = '0;
        exp_nerr = 2'd0;
        repeat (8) @(negedge clk);
        check("late_done_ignored", done_cnt - dc0, 0);
        check("late_done_idle", busy, 0);
        check("late_done_data_out", data_out, 0);

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   $urandom, $urandom, $urandom, $urandom,
                   2'($urandom_range(0, 2)),
                   int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                   1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute backstop so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
